// File: rtl/led_fifo_rd_sched.sv
// Read-side scheduler for the LED pixel FIFO.
// Paces reads from a NOREG FIFO into a framed valid/ready pixel stream.
// Every line is followed by a fixed blanking gap that carries the panel latch pulse.
module led_fifo_rd_sched #(
    parameter int DATA_W   = 12,
    parameter int LINE_LEN = 64,
    parameter int LINES    = 32,
    parameter int GAP_CYC  = 4
) (
    input  logic              clkr,
    input  logic              rst,
    input  logic              en,
    output logic              fifo_re,
    input  logic [DATA_W-1:0] fifo_do,
    input  logic              fifo_empty,
    input  logic              fifo_aempty,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_sol,
    output logic              m_eol,
    output logic              lat_pulse,
    output logic              frame_done,
    output logic              busy
);

    localparam int ISS_W  = $clog2(LINE_LEN + 1);
    localparam int SENT_W = $clog2(LINE_LEN);
    localparam int LINE_W = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [ISS_W-1:0]  ISS_MAX   = ISS_W'(LINE_LEN);
    localparam logic [SENT_W-1:0] SENT_LAST = SENT_W'(LINE_LEN - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM,
        GAP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ISS_W-1:0]  issued;
    logic [SENT_W-1:0] sent;
    logic [LINE_W-1:0] line_idx;
    logic [GAP_W-1:0]  gap_cnt;

    // Two-entry skid buffer: buf0 is the head presented downstream, buf1 the tail.
    logic [DATA_W-1:0] buf0;
    logic [DATA_W-1:0] buf1;
    logic [1:0]        occ;
    logic              inflight;

    logic       head_valid;
    logic       xfer;
    logic [2:0] committed;
    logic       credit_ok;
    logic       line_end;

    // A slot freed by a transfer in this cycle can be reused immediately,
    // which is what lets the stream run at one pixel per clock.
    assign head_valid = (occ != 2'd0);
    assign xfer       = head_valid & m_ready;
    assign committed  = {1'b0, occ} + {2'b00, inflight};
    assign credit_ok  = (committed - {2'b00, xfer}) < 3'd2;
    assign line_end   = (state == STREAM) && xfer && (sent == SENT_LAST);

    // State register.
    always_ff @(posedge clkr) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection; en only matters in IDLE and at the end of a gap.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = FILL;
            FILL:    if (!fifo_aempty) state_nxt = STREAM;
            STREAM:  if (line_end) state_nxt = GAP;
            GAP:     if (gap_cnt == GAP_LAST) state_nxt = en ? FILL : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: read enable gated by credit, empty flag and per-line read budget, plus framing flags.
    always_comb begin
        fifo_re    = 1'b0;
        if (!rst && (state == STREAM) && !fifo_empty && credit_ok && (issued < ISS_MAX)) begin
            fifo_re = 1'b1;
        end
        busy       = (state != IDLE);
        lat_pulse  = (state == GAP) && (gap_cnt == '0);
        m_valid    = head_valid;
        m_data     = buf0;
        m_sol      = head_valid && (sent == '0);
        m_eol      = head_valid && (sent == SENT_LAST);
        frame_done = line_end && (line_idx == LINE_LAST);
    end

    // Line bookkeeping: reads issued, pixels sent, line index and gap timer.
    always_ff @(posedge clkr) begin
        if (rst) begin
            issued   <= '0;
            sent     <= '0;
            line_idx <= '0;
            gap_cnt  <= '0;
        end else begin
            if (state == FILL) begin
                issued <= '0;
                sent   <= '0;
            end else begin
                if (fifo_re) begin
                    issued <= issued + ISS_W'(1);
                end
                if (xfer) begin
                    sent <= (sent == SENT_LAST) ? '0 : sent + SENT_W'(1);
                end
            end
            if (line_end) begin
                line_idx <= (line_idx == LINE_LAST) ? '0 : line_idx + LINE_W'(1);
            end
            if ((state == GAP) && (gap_cnt != GAP_LAST)) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    // Skid buffer: capture the word returned one cycle after each read, pop on transfer.
    // Reset also drops a pending read so its data is never captured.
    always_ff @(posedge clkr) begin
        if (rst) begin
            inflight <= 1'b0;
            occ      <= 2'd0;
            buf0     <= '0;
            buf1     <= '0;
        end else begin
            inflight <= fifo_re;
            case ({inflight, xfer})
                2'b10: begin
                    if (occ == 2'd0) begin
                        buf0 <= fifo_do;
                    end else begin
                        buf1 <= fifo_do;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf0 <= fifo_do;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= fifo_do;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_fifo_rd_sched.sv
// Testbench for led_fifo_rd_sched.
// A queue-based FIFO model feeds the DUT. Each word written is also turned into an expected pixel
// (data, sol, eol, frame_done) from the line/frame arithmetic. A negedge monitor pops and compares.
module tb_led_fifo_rd_sched;

    localparam int DATA_W   = 12;
    localparam int LINE_LEN = 64;
    localparam int LINES    = 2;
    localparam int GAP_CYC  = 4;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              sol;
        logic              eol;
        logic              fd;
    } exp_t;

    logic              clkr = 1'b0;
    logic              rst;
    logic              en;
    logic              fifo_re;
    logic [DATA_W-1:0] fifo_do;
    logic              fifo_empty;
    logic              fifo_aempty;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_sol;
    logic              m_eol;
    logic              lat_pulse;
    logic              frame_done;
    logic              busy;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];
    exp_t e;
    int   model_pos  = 0;
    int   model_line = 0;

    logic [DATA_W-1:0] fifo_q[$];
    int   written     = 0;
    int   loaded      = 0;
    bit   popped_last = 1'b0;

    int   cyc          = 0;
    int   xfer_cnt     = 0;
    int   total_reads  = 0;
    int   fd_cnt       = 0;
    int   outstanding  = 0;
    int   last_sol_cyc = -1;
    int   last_eol_cyc = -1;
    bit   tput_chk     = 1'b0;
    bit   hold_prev    = 1'b0;
    bit   prev_eol_x   = 1'b0;
    logic [DATA_W-1:0] hold_data = '0;

    led_fifo_rd_sched #(
        .DATA_W(DATA_W), .LINE_LEN(LINE_LEN), .LINES(LINES), .GAP_CYC(GAP_CYC)
    ) dut (
        .clkr(clkr), .rst(rst), .en(en),
        .fifo_re(fifo_re), .fifo_do(fifo_do), .fifo_empty(fifo_empty), .fifo_aempty(fifo_aempty),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_sol(m_sol), .m_eol(m_eol), .lat_pulse(lat_pulse),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clkr = ~clkr;

    // Watchdog so the run always ends even if the DUT locks up.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // FIFO model: NOREG read data one cycle after re, shares the DUT reset, flags registered.
    always @(posedge clkr) begin
        if (rst) begin
            fifo_q.delete();
            loaded      = written;
            popped_last = 1'b0;
        end else begin
            popped_last = 1'b0;
            if (fifo_re && fifo_q.size() > 0) begin
                fifo_do <= fifo_q.pop_front();
                popped_last = 1'b1;
            end
            while (loaded < written) begin
                fifo_q.push_back(DATA_W'(loaded));
                loaded++;
            end
        end
        fifo_empty  <= (fifo_q.size() == 0);
        fifo_aempty <= (fifo_q.size() < 4);
    end

    // Monitor: read-safety rules, backpressure stability, latch timing and scoreboard compare.
    always @(negedge clkr) begin
        cyc++;
        if (rst) begin
            outstanding = 0;
            hold_prev   = 1'b0;
            prev_eol_x  = 1'b0;
        end else begin
            if (fifo_re) begin
                checkOutput("re_while_empty", int'(fifo_empty), 0);
                checkOutput("re_credit", int'((outstanding - int'(m_valid && m_ready)) < 2), 1);
                total_reads++;
            end
            if (hold_prev) begin
                checkOutput("hold_valid", int'(m_valid), 1);
                checkOutput("hold_data", int'(m_data), int'(hold_data));
            end
            if (lat_pulse || prev_eol_x) begin
                checkOutput("lat_pulse", int'(lat_pulse), int'(prev_eol_x));
                checkOutput("gap_valid", int'(m_valid), 0);
            end
            if (frame_done) begin
                checkOutput("frame_done_qual", int'(m_valid && m_ready), 1);
                fd_cnt++;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_pixel", int'(m_data), -1);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("pix_data", int'(m_data), int'(e.data));
                    checkOutput("pix_sol", int'(m_sol), int'(e.sol));
                    checkOutput("pix_eol", int'(m_eol), int'(e.eol));
                    checkOutput("pix_frame_done", int'(frame_done), int'(e.fd));
                end
                if (m_sol) begin
                    if (tput_chk && last_eol_cyc >= 0) begin
                        checkOutput("gap_to_sol", cyc - last_eol_cyc, GAP_CYC + 4);
                    end
                    last_sol_cyc = cyc;
                end
                if (m_eol) begin
                    if (tput_chk) begin
                        checkOutput("line_cycles", cyc - last_sol_cyc, LINE_LEN - 1);
                    end
                    last_eol_cyc = cyc;
                end
                xfer_cnt++;
            end
            outstanding = outstanding + int'(fifo_re) - int'(m_valid && m_ready);
            hold_prev   = m_valid && !m_ready;
            hold_data   = m_data;
            prev_eol_x  = m_valid && m_ready && m_eol;
        end
    end

    task automatic tick();
        @(posedge clkr);
        #2;
    endtask

    // Write n words into the FIFO and queue the pixels they must become.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{DATA_W'(written), model_pos == 0, model_pos == LINE_LEN - 1,
                              (model_pos == LINE_LEN - 1) && (model_line == LINES - 1)});
            written++;
            model_pos++;
            if (model_pos == LINE_LEN) begin
                model_pos  = 0;
                model_line = (model_line + 1) % LINES;
            end
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput(name, exp_q.size(), 0);
    endtask

    task automatic wait_xfers(input string name, input int target, input int budget);
        int n = 0;
        while (xfer_cnt < target && n < budget) begin
            tick();
            n++;
        end
        checkOutput(name, int'(xfer_cnt >= target), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_fifo_re"}, int'(fifo_re), 0);
        checkOutput({tag, "_m_valid"}, int'(m_valid), 0);
        checkOutput({tag, "_m_sol"}, int'(m_sol), 0);
        checkOutput({tag, "_m_eol"}, int'(m_eol), 0);
        checkOutput({tag, "_lat_pulse"}, int'(lat_pulse), 0);
        checkOutput({tag, "_frame_done"}, int'(frame_done), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_m_data"}, int'(m_data), 0);
    endtask

    // Directed-plus-random sequence.
    initial begin
        int n;
        int base;
        rst     = 1'b1;
        en      = 1'b0;
        m_ready = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Two full lines at full rate, frame wraps after the second.
        applyStimulus(128);
        tick();
        tick();
        m_ready  = 1'b1;
        tput_chk = 1'b1;
        base     = total_reads;
        n        = fd_cnt;
        en       = 1'b1;
        begin
            int lat = 0;
            do begin
                tick();
                lat++;
            end while (!m_valid && lat < 20);
            checkOutput("first_valid_latency", lat, 4);
        end
        wait_drain("full_rate_drain", 400);
        tick();
        checkOutput("full_rate_reads", total_reads - base, 128);
        checkOutput("frame_done_count", fd_cnt - n, 1);
        tput_chk = 1'b0;

        // Random backpressure over one line.
        repeat (8) tick();
        applyStimulus(64);
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            m_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        checkOutput("backpressure_drain", exp_q.size(), 0);
        m_ready = 1'b1;

        // FIFO runs dry mid-line and is topped up later.
        repeat (8) tick();
        applyStimulus(10);
        repeat (20) tick();
        applyStimulus(54);
        wait_drain("dry_drain", 400);

        // en dropped mid-line: line finishes, then idle; next run continues the frame.
        repeat (8) tick();
        base = xfer_cnt;
        applyStimulus(64);
        wait_xfers("en_drop_progress", base + 30, 500);
        en = 1'b0;
        wait_drain("en_drop_drain", 400);
        repeat (GAP_CYC + 3) tick();
        checkOutput("idle_busy", int'(busy), 0);
        base = total_reads;
        applyStimulus(64);
        repeat (5) tick();
        checkOutput("idle_no_reads", total_reads - base, 0);
        checkOutput("idle_fifo_re", int'(fifo_re), 0);
        en = 1'b1;
        wait_drain("resume_drain", 400);

        // Reset mid-stream with a read in flight.
        repeat (8) tick();
        base = xfer_cnt;
        applyStimulus(64);
        wait_xfers("rst_progress", base + 10, 500);
        n = 0;
        while (!popped_last && n < 50) begin
            tick();
            n++;
        end
        checkOutput("rst_inflight_seen", int'(popped_last), 1);
        rst        = 1'b1;
        m_ready    = 1'b0;
        exp_q.delete();
        model_pos  = 0;
        model_line = 0;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        tick();
        applyStimulus(64);
        m_ready = 1'b1;
        wait_drain("restart_drain", 400);

        repeat (10) tick();
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
